// File: rtl/bg_control_unit.sv
// Frame sequencer for the background-removal PE array: sum phase, average, bg-removal phase.
// Latency: Start to Done is about 10 cycles plus the PE sum/removal times and NUM_PE reduction cycles.
// Backpressure: waits on the PE done/idle vectors; a watchdog drops into a sticky ERR if they stall.
module bg_control_unit #(
  parameter int NUM_PE     = 4,
  parameter int LOG2_TOTAL = 2,
  parameter int SUM_W      = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [NUM_PE-1:0]       pe_Qi,
  input  logic [NUM_PE-1:0]       pe_Qsd,
  input  logic [NUM_PE-1:0]       pe_Qbgd,
  input  logic [NUM_PE*SUM_W-1:0] pe_red_sum,
  input  logic [NUM_PE*SUM_W-1:0] pe_green_sum,
  input  logic [NUM_PE*SUM_W-1:0] pe_blue_sum,
  output logic                    Start_Sum,
  output logic                    Start_BgRemoval,
  output logic                    Ack,
  output logic [8:0]              red_exp,
  output logic [8:0]              green_exp,
  output logic [8:0]              blue_exp,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err
);

  localparam int ACC_W = SUM_W + LOG2_TOTAL;
  localparam int IDX_W = $clog2(NUM_PE);
  localparam int WD_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [10:0] {
    S_IDLE      = 11'b000_0000_0001,
    S_SUM_START = 11'b000_0000_0010,
    S_SUM_WAIT  = 11'b000_0000_0100,
    S_ACCUM     = 11'b000_0000_1000,
    S_AVG       = 11'b000_0001_0000,
    S_SUM_ACK   = 11'b000_0010_0000,
    S_BG_START  = 11'b000_0100_0000,
    S_BG_WAIT   = 11'b000_1000_0000,
    S_BG_ACK    = 11'b001_0000_0000,
    S_DONE      = 11'b010_0000_0000,
    S_ERR       = 11'b100_0000_0000
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WD_W-1:0]    r_wdog;
  logic [IDX_W-1:0]   r_idx;
  logic [ACC_W-1:0]   r_acc_r, r_acc_g, r_acc_b;
  logic [7:0]         r_exp_r, r_exp_g, r_exp_b;
  logic [SUM_W-1:0]   w_sel_r, w_sel_g, w_sel_b;
  logic               w_wd_exp;
  logic               w_in_wait;

  // Divide the accumulated sum by the pixel count and clamp to an 8-bit colour.
  function automatic logic [7:0] avg_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] q;
    q = acc >> LOG2_TOTAL;
    return (q > ACC_W'(255)) ? 8'hFF : q[7:0];
  endfunction

  assign w_wd_exp  = (r_wdog == WD_W'(TIMEOUT));
  assign w_in_wait = (r_state == S_SUM_WAIT) || (r_state == S_SUM_ACK) ||
                     (r_state == S_BG_WAIT)  || (r_state == S_BG_ACK);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a completing done vector beats a simultaneous watchdog expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (Start) w_next = S_SUM_START;
      S_SUM_START: w_next = S_SUM_WAIT;
      S_SUM_WAIT:  if (&pe_Qsd) w_next = S_ACCUM;
                   else if (w_wd_exp) w_next = S_ERR;
      S_ACCUM:     if (r_idx == IDX_W'(NUM_PE - 1)) w_next = S_AVG;
      S_AVG:       w_next = S_SUM_ACK;
      S_SUM_ACK:   if (&pe_Qi) w_next = S_BG_START;
                   else if (w_wd_exp) w_next = S_ERR;
      S_BG_START:  w_next = S_BG_WAIT;
      S_BG_WAIT:   if (&pe_Qbgd) w_next = S_BG_ACK;
                   else if (w_wd_exp) w_next = S_ERR;
      S_BG_ACK:    if (&pe_Qi) w_next = S_DONE;
                   else if (w_wd_exp) w_next = S_ERR;
      S_DONE:      w_next = S_IDLE;
      S_ERR:       w_next = S_ERR;
      default:     w_next = S_IDLE;
    endcase
  end

  // Watchdog: restarts on every state change, counts while parked in a wait state.
  always_ff @(posedge Clk) begin
    if (Reset)                     r_wdog <= '0;
    else if (w_next != r_state)    r_wdog <= '0;
    else if (w_in_wait)            r_wdog <= r_wdog + 1'b1;
  end

  // Select the sums of the PE currently being reduced.
  always_comb begin
    w_sel_r = '0;
    w_sel_g = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_r = pe_red_sum[k*SUM_W +: SUM_W];
        w_sel_g = pe_green_sum[k*SUM_W +: SUM_W];
        w_sel_b = pe_blue_sum[k*SUM_W +: SUM_W];
      end
    end
  end

  // Serial reduction of per-PE sums, one PE per cycle; cleared while waiting for the sums.
  always_ff @(posedge Clk) begin
    if (Reset || (r_state == S_SUM_WAIT)) begin
      r_idx   <= '0;
      r_acc_r <= '0;
      r_acc_g <= '0;
      r_acc_b <= '0;
    end else if (r_state == S_ACCUM) begin
      r_idx   <= r_idx + 1'b1;
      r_acc_r <= r_acc_r + ACC_W'(w_sel_r);
      r_acc_g <= r_acc_g + ACC_W'(w_sel_g);
      r_acc_b <= r_acc_b + ACC_W'(w_sel_b);
    end
  end

  // Expected background colour, captured once per frame and held until the next AVG.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_exp_r <= '0;
      r_exp_g <= '0;
      r_exp_b <= '0;
    end else if (r_state == S_AVG) begin
      r_exp_r <= avg_sat(r_acc_r);
      r_exp_g <= avg_sat(r_acc_g);
      r_exp_b <= avg_sat(r_acc_b);
    end
  end

  // Outputs decode straight from the one-hot state flops, so they are glitch-free.
  assign Start_Sum       = (r_state == S_SUM_START);
  assign Start_BgRemoval = (r_state == S_BG_START);
  assign Ack             = (r_state == S_SUM_ACK) || (r_state == S_BG_ACK) || (r_state == S_ERR);
  assign Busy            = (r_state != S_IDLE);
  assign Done            = (r_state == S_DONE);
  assign Err             = (r_state == S_ERR);
  assign red_exp         = {1'b0, r_exp_r};
  assign green_exp       = {1'b0, r_exp_g};
  assign blue_exp        = {1'b0, r_exp_b};

endmodule

// File: tb/tb_bg_control_unit.sv
// Bench for bg_control_unit: PE array behaviour modelled per cycle, averages from plain arithmetic.
// Each task runs one scenario and checks its own results.
module tb_bg_control_unit;
  localparam int NUM_PE     = 4;
  localparam int LOG2_TOTAL = 2;
  localparam int SUM_W      = 9;
  localparam int TIMEOUT    = 255;
  localparam int NEVER      = 100000;

  logic                    Clk;
  logic                    Reset;
  logic                    Start;
  logic [NUM_PE-1:0]       pe_Qi, pe_Qsd, pe_Qbgd;
  logic [NUM_PE*SUM_W-1:0] pe_red_sum, pe_green_sum, pe_blue_sum;
  logic                    Start_Sum, Start_BgRemoval, Ack, Busy, Done, Err;
  logic [8:0]              red_exp, green_exp, blue_exp;

  bg_control_unit #(.NUM_PE(NUM_PE), .LOG2_TOTAL(LOG2_TOTAL), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .pe_Qi(pe_Qi), .pe_Qsd(pe_Qsd), .pe_Qbgd(pe_Qbgd),
    .pe_red_sum(pe_red_sum), .pe_green_sum(pe_green_sum), .pe_blue_sum(pe_blue_sum),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dly_s[NUM_PE], dly_b[NUM_PE], cnt_s[NUM_PE], cnt_b[NUM_PE];
  int sr[NUM_PE], sg[NUM_PE], sbl[NUM_PE];
  int n_ss, n_sb, n_done, n_ack, sb_step, busy_gaps, busy_after;

  // Expected colour: mean over all pixels, clamped to 255.
  function automatic int exp_ref(input int ch);
    int tot = 0;
    for (int k = 0; k < NUM_PE; k++)
      tot += (ch == 0) ? sr[k] : (ch == 1) ? sg[k] : sbl[k];
    tot = tot / (1 << LOG2_TOTAL);
    return (tot > 255) ? 255 : tot;
  endfunction

  task automatic load_sums();
    for (int k = 0; k < NUM_PE; k++) begin
      pe_red_sum[k*SUM_W +: SUM_W]   = SUM_W'(sr[k]);
      pe_green_sum[k*SUM_W +: SUM_W] = SUM_W'(sg[k]);
      pe_blue_sum[k*SUM_W +: SUM_W]  = SUM_W'(sbl[k]);
    end
  endtask

  task automatic rand_sums(input int lo);
    for (int k = 0; k < NUM_PE; k++) begin
      sr[k]  = $urandom_range(511, lo);
      sg[k]  = $urandom_range(511, lo);
      sbl[k] = $urandom_range(511, lo);
    end
    load_sums();
  endtask

  task automatic pe_clear();
    pe_Qi = '1; pe_Qsd = '0; pe_Qbgd = '0;
    for (int k = 0; k < NUM_PE; k++) begin cnt_s[k] = 0; cnt_b[k] = 0; end
  endtask

  task automatic clr_counts();
    n_ss = 0; n_sb = 0; n_done = 0; n_ack = 0; sb_step = -1;
  endtask

  // One clock: sample DUT just after the edge, then advance the PE-array model.
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (Start_Sum) n_ss++;
    if (Start_BgRemoval) begin n_sb++; sb_step = cyc; end
    if (Done) n_done++;
    if (Ack) n_ack++;
    for (int k = 0; k < NUM_PE; k++) begin
      if (Start_Sum) begin
        pe_Qsd[k] = 1'b0; pe_Qi[k] = 1'b0; cnt_s[k] = dly_s[k];
      end else if (cnt_s[k] > 0) begin
        cnt_s[k]--;
        if (cnt_s[k] == 0) begin pe_Qsd[k] = 1'b1; pe_Qi[k] = 1'b1; end
      end
      if (Start_BgRemoval) begin
        pe_Qbgd[k] = 1'b0; pe_Qi[k] = 1'b0; cnt_b[k] = dly_b[k];
      end else if (cnt_b[k] > 0) begin
        cnt_b[k]--;
        if (cnt_b[k] == 0) begin pe_Qbgd[k] = 1'b1; pe_Qi[k] = 1'b1; end
      end
    end
  endtask

  // Drive one frame to completion; optionally pulse Start while the machine sits in BG_WAIT.
  task automatic run_frame(input bit stray_start);
    clr_counts();
    busy_gaps = 0; busy_after = 0;
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 1000 && n_done == 0; i++) begin
      if (!Busy) busy_gaps++;
      Start = stray_start && (sb_step >= 0) && (cyc == sb_step + 1);
      step();
    end
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (Busy) busy_after++; end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; pe_clear();
    for (int k = 0; k < NUM_PE; k++) begin sr[k] = 0; sg[k] = 0; sbl[k] = 0; dly_s[k] = 1; dly_b[k] = 1; end
    load_sums();
    repeat (3) step();
    checks++;
    if ({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {Start_Sum, Start_BgRemoval, Ack, Busy, Done, Err});
    end
    checks++;
    if ({red_exp, green_exp, blue_exp} !== 27'd0) begin
      errors++; $display("FAIL reset_exp got %0d/%0d/%0d want 0/0/0", red_exp, green_exp, blue_exp);
    end
    Reset = 1'b0;
    repeat (2) step();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy=%b want 0", Busy); end
  endtask

  task automatic test_average();
    sr  = '{100, 120, 140, 160};
    sg  = '{0, 0, 0, 0};
    sbl = '{255, 255, 255, 255};
    dly_s = '{3, 3, 3, 3}; dly_b = '{3, 3, 3, 3};
    load_sums();
    run_frame(1'b0);
    checks++;
    if (red_exp !== 9'd130) begin errors++; $display("FAIL avg_red got %0d want 130", red_exp); end
    checks++;
    if (green_exp !== 9'd0) begin errors++; $display("FAIL avg_green got %0d want 0", green_exp); end
    checks++;
    if (blue_exp !== 9'd255) begin errors++; $display("FAIL avg_blue got %0d want 255", blue_exp); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL avg_done got %0d want 1", n_done); end
  endtask

  task automatic test_staggered();
    rand_sums(0);
    dly_s = '{2, 5, 9, 4}; dly_b = '{2, 5, 9, 4};
    run_frame(1'b0);
    checks++;
    if ({n_ss, n_sb, n_done} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL stag_pulses got ss=%0d sb=%0d done=%0d want 1/1/1", n_ss, n_sb, n_done);
    end
    checks++;
    if (busy_gaps !== 0) begin errors++; $display("FAIL stag_busy_in_frame low_cycles=%0d want 0", busy_gaps); end
    checks++;
    if (busy_after !== 0) begin errors++; $display("FAIL stag_busy_after high_cycles=%0d want 0", busy_after); end
    checks++;
    if (n_ack !== 2) begin errors++; $display("FAIL stag_ack_cycles got %0d want 2", n_ack); end
    checks++;
    if ({red_exp, green_exp, blue_exp} !== {9'(exp_ref(0)), 9'(exp_ref(1)), 9'(exp_ref(2))}) begin
      errors++; $display("FAIL stag_exp got %0d/%0d/%0d want %0d/%0d/%0d",
                         red_exp, green_exp, blue_exp, exp_ref(0), exp_ref(1), exp_ref(2));
    end
  endtask

  task automatic test_saturate();
    rand_sums(0);
    sr = '{400, 400, 400, 400};
    load_sums();
    dly_s = '{1, 2, 3, 4}; dly_b = '{4, 3, 2, 1};
    run_frame(1'b0);
    checks++;
    if (red_exp !== 9'd255) begin errors++; $display("FAIL sat_red got %0d want 255", red_exp); end
    checks++;
    if ({green_exp, blue_exp} !== {9'(exp_ref(1)), 9'(exp_ref(2))}) begin
      errors++; $display("FAIL sat_gb got %0d/%0d want %0d/%0d", green_exp, blue_exp, exp_ref(1), exp_ref(2));
    end
  endtask

  task automatic test_timeout();
    int err_step = -1;
    int hold_bad = 0;
    rand_sums(0);
    dly_s = '{3, 3, 3, 3}; dly_b = '{3, 4, NEVER, 2};
    clr_counts();
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 100 && sb_step < 0; i++) step();
    for (int i = 0; i < 400 && !Err; i++) step();
    if (Err) err_step = cyc;
    // BG_WAIT is entered one cycle after the start pulse; ERR follows TIMEOUT+1 cycles later.
    checks++;
    if (err_step - sb_step !== TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_latency got %0d want %0d", err_step - sb_step, TIMEOUT + 2);
    end
    checks++;
    if (Ack !== 1'b1) begin errors++; $display("FAIL timeout_ack got %b want 1", Ack); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(Err && Ack) || Done) hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL timeout_hold bad_cycles=%0d want 0", hold_bad); end
    Reset = 1'b1; step(); Reset = 1'b0; pe_clear();
    checks++;
    if ({Err, Ack, Busy} !== 3'b0) begin errors++; $display("FAIL timeout_reset got %b want 000", {Err, Ack, Busy}); end
  endtask

  task automatic test_start_ignored();
    rand_sums(64);
    for (int k = 0; k < NUM_PE; k++) begin dly_s[k] = $urandom_range(8, 1); dly_b[k] = $urandom_range(8, 2); end
    run_frame(1'b1);
    checks++;
    if ({n_ss, n_done} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL stray_pulses got ss=%0d done=%0d want 1/1", n_ss, n_done);
    end
    checks++;
    if (busy_after !== 0) begin errors++; $display("FAIL stray_restart busy_cycles=%0d want 0", busy_after); end
    checks++;
    if ({red_exp, green_exp, blue_exp} !== {9'(exp_ref(0)), 9'(exp_ref(1)), 9'(exp_ref(2))}) begin
      errors++; $display("FAIL exp_hold got %0d/%0d/%0d want %0d/%0d/%0d",
                         red_exp, green_exp, blue_exp, exp_ref(0), exp_ref(1), exp_ref(2));
    end
  endtask

  task automatic test_reset_mid();
    int reached = 0;
    rand_sums(0);
    dly_s = '{2, 3, 1, 2}; dly_b = '{2, 2, 2, 2};
    clr_counts();
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 100 && !(n_ss > 0 && (&pe_Qsd)); i++) step();
    if (n_ss > 0 && (&pe_Qsd)) reached = 1;
    checks++;
    if (reached !== 1) begin errors++; $display("FAIL mid_reach_sums got %0d want 1", reached); end
    step();
    Reset = 1'b1; step(); Reset = 1'b0;
    checks++;
    if ({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Err, red_exp, green_exp, blue_exp} !== 33'd0) begin
      errors++; $display("FAIL mid_reset_out got busy=%b ack=%b done=%b exp=%0d/%0d/%0d want all 0",
                         Busy, Ack, Done, red_exp, green_exp, blue_exp);
    end
    pe_clear();
    repeat (20) step();
    checks++;
    if ({n_done, n_sb} !== {32'd0, 32'd0} || Busy !== 1'b0) begin
      errors++; $display("FAIL mid_after got done=%0d sb=%0d busy=%b want 0/0/0", n_done, n_sb, Busy);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      rand_sums(0);
      for (int k = 0; k < NUM_PE; k++) begin dly_s[k] = $urandom_range(12, 1); dly_b[k] = $urandom_range(12, 1); end
      run_frame(1'b0);
      checks++;
      if ({red_exp, green_exp, blue_exp} !== {9'(exp_ref(0)), 9'(exp_ref(1)), 9'(exp_ref(2))}) begin
        errors++; $display("FAIL rand_exp frame %0d got %0d/%0d/%0d want %0d/%0d/%0d", f,
                           red_exp, green_exp, blue_exp, exp_ref(0), exp_ref(1), exp_ref(2));
      end
      checks++;
      if ({n_done, n_ack} !== {32'd1, 32'd2}) begin
        errors++; $display("FAIL rand_hs frame %0d got done=%0d ack=%0d want 1/2", f, n_done, n_ack);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0;
    pe_Qi = '1; pe_Qsd = '0; pe_Qbgd = '0;
    pe_red_sum = '0; pe_green_sum = '0; pe_blue_sum = '0;
    test_reset();
    test_average();
    test_staggered();
    test_saturate();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
